// File: rtl/scfifo_flags.sv
// Single-clock FIFO with a registered read port, fill level, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module scfifo_flags #(
  parameter int W        = 8,
  parameter int L        = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         wr,
  input  logic [W-1:0] data_in,
  input  logic         rd,
  output logic [W-1:0] data_out,
  output logic         data_valid,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [L:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int         DEPTH   = 1 << L;
  localparam logic [L:0] DEPTH_C = (L+1)'(DEPTH);
  localparam logic [L:0] AF_C    = (L+1)'(AF_LEVEL);
  localparam logic [L:0] AE_C    = (L+1)'(AE_LEVEL);
  localparam logic [L:0] PTR_ONE = (L+1)'(1);

  logic [W-1:0] mem_q [DEPTH];

  logic [L:0]   wr_ptr_q, wr_ptr_d;
  logic [L:0]   rd_ptr_q, rd_ptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         dvalid_q, dvalid_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  logic [L:0]   count_w;
  logic         full_w, empty_w;
  logic         wr_acc, rd_acc;

  // The extra pointer bit distinguishes full from empty when the low bits match.
  assign count_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (count_w == DEPTH_C);
  assign empty_w = (count_w == '0);

  assign wr_acc = !wr && !full_w  && !clear;
  assign rd_acc = !rd && !empty_w && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (!wr && full_w)  ovf_d = 1'b1;
      if (!rd && empty_w) unf_d = 1'b1;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = mem_q[rd_ptr_q[L-1:0]];
        dvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[L-1:0]] <= data_in;
  end

  assign data_out     = dout_q;
  assign data_valid   = dvalid_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_w >= AF_C);
  assign almost_empty = (count_w <= AE_C);
  assign count        = count_w;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_scfifo_flags.sv
// Self-checking bench for scfifo_flags: directed and random steps compared cycle by cycle
// against a queue-based reference model of the FIFO.
module tb_scfifo_flags;

  localparam int W = 8;
  localparam int L = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic         clk = 1'b0;
  logic         reset, clear, wr, rd;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [L:0]   count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  logic         m_dv, m_ovf, m_unf;

  scfifo_flags #(.W(W), .L(L), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
    chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, ".dvalid"}, 32'(data_valid), 32'(m_dv));
    chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_dv = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, then compare.
  task automatic step(input string tag, input bit wr_n, input bit rd_n, input bit clr,
                      input logic [W-1:0] d);
    bit was_full, was_empty;
    wr = wr_n; rd = rd_n; clear = clr; data_in = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    m_dv = 1'b0;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (!wr_n && was_full)  m_ovf = 1'b1;
      if (!rd_n && was_empty) m_unf = 1'b1;
      if (!rd_n && !was_empty) begin
        m_dout = q.pop_front();
        m_dv = 1'b1;
      end
      if (!wr_n && !was_full) q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [W-1:0] ctr;
    reset = 1'b1; clear = 1'b0; wr = 1'b1; rd = 1'b1; data_in = '0;
    model_reset();

    // reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_all("reset");
    for (int i = 0; i < 10; i++) step("idle", 1, 1, 0, 8'h00);

    // fill 0x01..0x10, then drain
    for (int i = 1; i <= 16; i++) step("fill", 0, 1, 0, W'(i));
    for (int i = 0; i < 16; i++) step("drain", 1, 0, 0, 8'h00);
    step("drained_idle", 1, 1, 0, 8'h00);

    // overflow: 17 writes, underflow: 17 reads, then flush
    for (int i = 0; i < 17; i++) step("ovf_wr", 0, 1, 0, W'($urandom));
    for (int i = 0; i < 17; i++) step("unf_rd", 1, 0, 0, 8'h00);
    step("clear", 1, 1, 1, 8'h00);

    // simultaneous rd/wr at count 8
    for (int i = 0; i < 8; i++) step("pre8", 0, 1, 0, W'($urandom));
    for (int i = 0; i < 20; i++) step("rdwr8", 0, 0, 0, W'($urandom));
    chk("rdwr8_level", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) step("to_full", 0, 1, 0, W'($urandom));
    step("rdwr_full", 0, 0, 0, 8'hEE);
    chk("rdwr_full_level", 32'(count), 32'd15);
    step("clear2", 1, 1, 1, 8'h00);
    step("rdwr_empty", 0, 0, 0, 8'h3C);
    chk("rdwr_empty_level", 32'(count), 32'd1);
    step("clear_with_rdwr", 0, 0, 1, 8'h77);

    // pointer wrap: 3-write/2-read bursts with incrementing data
    ctr = 8'h00;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 3; i++) begin
        step("wrap_wr", 0, 1, 0, ctr);
        ctr++;
      end
      for (int i = 0; i < 2; i++) step("wrap_rd", 1, 0, 0, 8'h00);
    end
    step("clear3", 1, 1, 1, 8'h00);

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++)
      step("rand", bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0), W'($urandom));

    // async reset mid-stream at count 9, between clock edges
    step("clear4", 1, 1, 1, 8'h00);
    for (int i = 0; i < 9; i++) step("pre_rst", 0, 1, 0, W'($urandom));
    step("pre_rst_rd", 1, 0, 0, 8'h00);
    step("pre_rst_wr", 0, 1, 0, 8'h99);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    reset = 1'b0;
    step("post_rst_wr", 0, 1, 0, 8'hA5);
    step("post_rst_rd", 1, 0, 0, 8'h00);
    chk("a5_readback", 32'(data_out), 32'h0000_00A5);
    step("post_rst_idle", 1, 1, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
